// File: rtl/retro_catc_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : retro_catc_scheduler                                            |
// | Purpose  : Withholds core clock-enables while a stage stalls, then repays  |
// |            the owed ticks as spaced catch-up enables.                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module retro_catc_scheduler #(
  parameter int DEBT_WIDTH = 8,
  parameter int GAP        = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ClkEn,
  input  logic                  Delay,
  output logic                  ClkEnOut,
  output logic [DEBT_WIDTH-1:0] Debt,
  output logic                  Lagging,
  output logic                  Overflow
);

  localparam int c_space_w = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [DEBT_WIDTH:0]  c_debt_max = {1'b0, {DEBT_WIDTH{1'b1}}};
  localparam logic [c_space_w-1:0] c_gap      = c_space_w'(GAP);
  localparam logic [c_space_w-1:0] c_one      = c_space_w'(1);

  logic                  r_clkenout;
  logic [DEBT_WIDTH-1:0] r_debt;
  logic                  r_lagging;
  logic                  r_overflow;
  logic [c_space_w-1:0]  r_space;

  logic [DEBT_WIDTH:0]   w_pending;
  logic [DEBT_WIDTH:0]   w_remain;
  logic                  w_issue;
  logic                  w_sat;
  logic [DEBT_WIDTH-1:0] w_next_debt;
  logic [c_space_w-1:0]  w_next_space;

  // Pending is one bit wider so a tick arriving at saturated debt is visible.
  always_comb begin
    w_pending    = {1'b0, r_debt} + {{DEBT_WIDTH{1'b0}}, ClkEn};
    w_issue      = !Delay && (w_pending != '0) && (r_space == '0);
    w_remain     = w_pending - {{DEBT_WIDTH{1'b0}}, w_issue};
    w_sat        = (w_remain > c_debt_max);
    w_next_debt  = w_sat ? c_debt_max[DEBT_WIDTH-1:0] : w_remain[DEBT_WIDTH-1:0];
    w_next_space = r_space;
    if (w_issue) begin
      w_next_space = c_gap;
    end else if (r_space != '0) begin
      w_next_space = r_space - c_one;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_clkenout <= 1'b0;
      r_debt     <= '0;
      r_lagging  <= 1'b0;
      r_overflow <= 1'b0;
      r_space    <= '0;
    end else begin
      r_clkenout <= w_issue;
      r_debt     <= w_next_debt;
      r_lagging  <= (w_next_debt != '0);
      r_space    <= w_next_space;
      if (w_sat) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign ClkEnOut = r_clkenout;
  assign Debt     = r_debt;
  assign Lagging  = r_lagging;
  assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_retro_catc_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_retro_catc_scheduler                                         |
// | Purpose  : Directed bench for three scheduler configurations against an    |
// |            owed-tick reference model.                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_retro_catc_scheduler;

  logic clk;
  logic in_rst   [3];
  logic in_clken [3];
  logic in_delay [3];

  logic       o_out  [3];
  logic [7:0] o_debt [3];
  logic       o_lag  [3];
  logic       o_ovf  [3];

  logic [7:0] w_debt0;
  logic [1:0] w_debt1;
  logic [7:0] w_debt2;

  int n_vec;
  int n_fail;
  bit started;

  // Instance 0: defaults, instance 1: 2-bit debt, instance 2: no spacing.
  int c_max [3] = '{255, 3, 255};
  int c_gap [3] = '{1, 1, 0};

  int m_debt  [3];
  int m_space [3];
  bit m_out   [3];
  bit m_ovf   [3];

  retro_catc_scheduler #(.DEBT_WIDTH(8), .GAP(1)) u_dut0 (
    .Clk(clk), .Reset(in_rst[0]), .ClkEn(in_clken[0]), .Delay(in_delay[0]),
    .ClkEnOut(o_out[0]), .Debt(w_debt0), .Lagging(o_lag[0]), .Overflow(o_ovf[0])
  );
  retro_catc_scheduler #(.DEBT_WIDTH(2), .GAP(1)) u_dut1 (
    .Clk(clk), .Reset(in_rst[1]), .ClkEn(in_clken[1]), .Delay(in_delay[1]),
    .ClkEnOut(o_out[1]), .Debt(w_debt1), .Lagging(o_lag[1]), .Overflow(o_ovf[1])
  );
  retro_catc_scheduler #(.DEBT_WIDTH(8), .GAP(0)) u_dut2 (
    .Clk(clk), .Reset(in_rst[2]), .ClkEn(in_clken[2]), .Delay(in_delay[2]),
    .ClkEnOut(o_out[2]), .Debt(w_debt2), .Lagging(o_lag[2]), .Overflow(o_ovf[2])
  );

  assign o_debt[0] = w_debt0;
  assign o_debt[1] = {6'b0, w_debt1};
  assign o_debt[2] = w_debt2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: a tick counter that is paid back one enable at a time,
  // no faster than once every GAP+1 cycles, clamped at its maximum.
  always @(posedge clk) begin
    started <= 1'b1;
    for (int k = 0; k < 3; k++) begin
      int  pend;
      int  rem;
      bit  iss;
      if (!in_rst[k]) begin
        m_debt[k]  <= 0;
        m_space[k] <= 0;
        m_out[k]   <= 1'b0;
        m_ovf[k]   <= 1'b0;
      end else begin
        pend = m_debt[k] + (in_clken[k] ? 1 : 0);
        iss  = !in_delay[k] && (pend > 0) && (m_space[k] == 0);
        rem  = pend - (iss ? 1 : 0);
        if (rem > c_max[k]) begin
          rem = c_max[k];
          m_ovf[k] <= 1'b1;
        end
        m_debt[k]  <= rem;
        m_out[k]   <= iss;
        m_space[k] <= iss ? c_gap[k] : ((m_space[k] > 0) ? m_space[k] - 1 : 0);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("clkenout", k, {31'b0, o_out[k]}, {31'b0, m_out[k]});
        chk("debt",     k, {24'b0, o_debt[k]}, m_debt[k]);
        chk("lagging",  k, {31'b0, o_lag[k]}, (m_debt[k] != 0) ? 1 : 0);
        chk("overflow", k, {31'b0, o_ovf[k]}, {31'b0, m_ovf[k]});
      end
    end
  end

  // Drive one cycle of inputs; on return the registered outputs reflect it.
  task automatic step(input int k, input logic ce, input logic dl);
    in_clken[k] = ce;
    in_delay[k] = dl;
    @(negedge clk);
    in_clken[k] = 1'b0;
  endtask

  initial begin
    int pulses;
    int ticks;
    n_vec   = 0;
    n_fail  = 0;
    for (int k = 0; k < 3; k++) begin
      in_rst[k]   = 1'b0;
      in_clken[k] = 1'b0;
      in_delay[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out",  k, {31'b0, o_out[k]}, 0);
      chk("rst_debt", k, {24'b0, o_debt[k]}, 0);
      chk("rst_lag",  k, {31'b0, o_lag[k]}, 0);
      chk("rst_ovf",  k, {31'b0, o_ovf[k]}, 0);
      in_rst[k] = 1'b1;
    end

    // Undelayed ticks every 4th cycle: one pulse, one cycle later, no debt.
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 4) == 0, 1'b0);
      chk("s1_out",  0, {31'b0, o_out[0]}, ((i % 4) == 0) ? 1 : 0);
      chk("s1_debt", 0, {24'b0, o_debt[0]}, 0);
    end

    // 40 stalled cycles with a tick every 8 accrue 5, then repaid as 5 extras.
    for (int i = 0; i < 40; i++) step(0, (i % 8) == 0, 1'b1);
    chk("s2_debt", 0, {24'b0, o_debt[0]}, 5);
    chk("s2_lag",  0, {31'b0, o_lag[0]}, 1);
    pulses = 0;
    ticks  = 0;
    for (int i = 0; i < 48; i++) begin
      step(0, (i < 40) && ((i % 8) == 0), 1'b0);
      if ((i < 40) && ((i % 8) == 0)) ticks++;
      if (o_out[0]) pulses++;
    end
    chk("s2_extra", 0, pulses - ticks, 5);
    chk("s2_drain", 0, {24'b0, o_debt[0]}, 0);

    // Debt 1 with a tick on the cycle the stall releases.
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0);
    chk("s4_out",  0, {31'b0, o_out[0]}, 1);
    chk("s4_debt", 0, {24'b0, o_debt[0]}, 1);
    repeat (4) step(0, 1'b0, 1'b0);

    // Reset in the middle of a catch-up discards the debt.
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0);
    chk("s5_debt4", 0, {24'b0, o_debt[0]}, 4);
    in_rst[0] = 1'b0;
    step(0, 1'b0, 1'b0);
    chk("s5_out",  0, {31'b0, o_out[0]}, 0);
    chk("s5_debt", 0, {24'b0, o_debt[0]}, 0);
    chk("s5_lag",  0, {31'b0, o_lag[0]}, 0);
    in_rst[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1'b0, 1'b0);
      if (o_out[0]) pulses++;
    end
    chk("s5_nopulse", 0, pulses, 0);

    // Two-bit debt saturates at 3; the fourth stalled tick sets Overflow.
    for (int t = 1; t <= 6; t++) begin
      step(1, 1'b1, 1'b1);
      if (t == 3) chk("s3_ovf3", 1, {31'b0, o_ovf[1]}, 0);
      if (t == 4) begin
        chk("s3_ovf4",  1, {31'b0, o_ovf[1]}, 1);
        chk("s3_debt4", 1, {24'b0, o_debt[1]}, 3);
      end
      repeat (3) step(1, 1'b0, 1'b1);
    end
    repeat (10) step(1, 1'b0, 1'b0);
    chk("s3_drain",  1, {24'b0, o_debt[1]}, 0);
    chk("s3_sticky", 1, {31'b0, o_ovf[1]}, 1);

    // No spacing: three owed ticks come out back to back.
    repeat (3) step(2, 1'b1, 1'b1);
    chk("s6_debt3", 2, {24'b0, o_debt[2]}, 3);
    for (int i = 0; i < 5; i++) begin
      step(2, 1'b0, 1'b0);
      chk("s6_out", 2, {31'b0, o_out[2]}, (i < 3) ? 1 : 0);
    end
    chk("s6_debt0", 2, {24'b0, o_debt[2]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
